// File: rtl/memory_response_unit_pkg.sv
// Shared types and defaults for the memory response unit: RAM handshake states,
// responder FSM states and the abort timing constants.
package memory_response_unit_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DSERV = 3'd1,
        ISERV = 3'd2,
        DDONE = 3'd3,
        IDONE = 3'd4
    } memresp_state_t;

    localparam int    DEF_TIMEOUT  = 64;
    localparam word_t DEF_ERR_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/memory_response_unit.sv
// Single-ported RAM responder: serves one data or instruction access at a time
// (data first), returns one-cycle hit pulses and aborts stalled accesses.
module memory_response_unit
    import memory_response_unit_pkg::*;
#(
    parameter int    TIMEOUT  = DEF_TIMEOUT,
    parameter word_t ERR_WORD = DEF_ERR_WORD
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] imemload,
    output logic [31:0] dmemload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    memresp_state_t       state_r, next_state_s;
    logic [TIMER_W-1:0]   timer_r, next_timer_s;
    logic                 d_latch_s, i_latch_s, d_abort_s, i_abort_s;
    logic                 ram_ok_s, ram_fail_s;

    // The timer only counts within a service state; anywhere else it rests at zero
    // so every new service starts from a clean count.
    assign ram_ok_s   = (ramstate == ACCESS);
    assign ram_fail_s = (ramstate == ERROR) || (timer_r == TIMER_W'(TIMEOUT - 1));

    // Next-state, RAM strobe and hit decode
    always_comb begin
        next_state_s = state_r;
        next_timer_s = '0;
        d_latch_s    = 1'b0;
        i_latch_s    = 1'b0;
        d_abort_s    = 1'b0;
        i_abort_s    = 1'b0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = 32'h0000_0000;
        ramstore     = 32'h0000_0000;
        ihit         = 1'b0;
        dhit         = 1'b0;
        case (state_r)
            IDLE: begin
                if (dmemREN || dmemWEN) begin
                    next_state_s = DSERV;
                end else if (imemREN && !halt) begin
                    next_state_s = ISERV;
                end else begin
                    next_state_s = IDLE;
                end
            end
            DSERV: begin
                ramaddr  = dmemaddr;
                ramWEN   = dmemWEN;
                ramREN   = dmemREN && !dmemWEN;
                ramstore = dmemstore;
                if (ram_ok_s) begin
                    d_latch_s    = dmemREN && !dmemWEN;
                    next_state_s = DDONE;
                end else if (ram_fail_s) begin
                    d_abort_s    = 1'b1;
                    next_state_s = DDONE;
                end else begin
                    next_timer_s = timer_r + TIMER_W'(1);
                end
            end
            ISERV: begin
                ramaddr = imemaddr;
                ramREN  = 1'b1;
                if (ram_ok_s) begin
                    i_latch_s    = 1'b1;
                    next_state_s = IDONE;
                end else if (ram_fail_s) begin
                    i_abort_s    = 1'b1;
                    next_state_s = IDONE;
                end else begin
                    next_timer_s = timer_r + TIMER_W'(1);
                end
            end
            DDONE: begin
                dhit         = 1'b1;
                next_state_s = IDLE;
            end
            IDONE: begin
                ihit         = 1'b1;
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, timer, load registers and sticky error flag
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r  <= IDLE;
            timer_r  <= '0;
            imemload <= 32'h0000_0000;
            dmemload <= 32'h0000_0000;
            err      <= 1'b0;
        end else begin
            state_r <= next_state_s;
            timer_r <= next_timer_s;
            if (d_latch_s) begin
                dmemload <= ramload;
            end else if (d_abort_s) begin
                dmemload <= ERR_WORD;
            end
            if (i_latch_s) begin
                imemload <= ramload;
            end else if (i_abort_s) begin
                imemload <= ERR_WORD;
            end
            if (d_abort_s || i_abort_s) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_memory_response_unit.sv
// Bench for memory_response_unit: a latency-programmable RAM responder plus a
// transaction-level model of contents, hit timing, abort and error behaviour.
module tb_memory_response_unit;
    import memory_response_unit_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        halt, imemREN, dmemREN, dmemWEN;
    logic [31:0] imemaddr, dmemaddr, dmemstore;
    logic        ihit, dhit, ramREN, ramWEN, err;
    logic [31:0] imemload, dmemload, ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    int n_checks = 0;
    int n_fail   = 0;

    memory_response_unit dut (
        .CLK(CLK), .nRST(nRST), .halt(halt),
        .imemREN(imemREN), .imemaddr(imemaddr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .ihit(ihit), .dhit(dhit), .imemload(imemload), .dmemload(dmemload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_word(input logic [7:0] i);
        return {8'hA5, i, ~i, i ^ 8'h3C};
    endfunction

    // RAM environment: answers ACCESS after ram_lat BUSY cycles, or ERROR when ram_err
    logic [31:0]  ram_mem [0:255];
    logic [255:0] ram_wr;
    int           ram_lat = 0;
    bit           ram_err = 1'b0;
    int           ram_cnt = 0;

    always @(negedge CLK) begin
        if (ramREN || ramWEN) begin
            if (ram_err) begin
                ramstate <= ERROR;
                ram_cnt  <= 0;
            end else if (ram_cnt >= ram_lat) begin
                ramstate <= ACCESS;
                ramload  <= (ram_wr[ramaddr[9:2]] === 1'b1) ? ram_mem[ramaddr[9:2]]
                                                            : init_word(ramaddr[9:2]);
                if (ramWEN) begin
                    ram_mem[ramaddr[9:2]] <= ramstore;
                    ram_wr[ramaddr[9:2]]  <= 1'b1;
                end
                ram_cnt <= 0;
            end else begin
                ramstate <= BUSY;
                ramload  <= 32'h0;
                ram_cnt  <= ram_cnt + 1;
            end
        end else begin
            ramstate <= FREE;
            ramload  <= 32'h0;
            ram_cnt  <= 0;
        end
    end

    // Reference model state
    logic [31:0] model_mem [0:255];
    bit          model_err;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One transaction from IDLE; called on a falling edge, returns on a falling edge in IDLE.
    task automatic run_txn(input logic dr, input logic dw, input logic ir,
                           input logic [31:0] da, input logic [31:0] ia, input logic [31:0] st,
                           input int lat, input bit rerr, input string nm,
                           output logic [31:0] got_dl, output logic [31:0] got_il);
        bit          want_d, want_i, got_d, got_i, ab;
        int          eff, exp_d_cyc, exp_i_cyc, cyc;
        logic [31:0] exp_dl, exp_il;
        want_d = dr | dw;
        want_i = ir;
        ab  = rerr || (lat > DEF_TIMEOUT - 1);
        eff = rerr ? 0 : (ab ? DEF_TIMEOUT - 1 : lat);
        exp_dl = 32'h0;
        exp_il = 32'h0;
        exp_d_cyc = 2 + eff;
        if (want_d) begin
            if (ab) exp_dl = DEF_ERR_WORD;
            else if (dw) model_mem[da[9:2]] = st;
            else exp_dl = model_mem[da[9:2]];
        end
        exp_i_cyc = want_d ? exp_d_cyc + 3 + eff : 2 + eff;
        if (want_i) exp_il = ab ? DEF_ERR_WORD : model_mem[ia[9:2]];
        if (ab && (want_d || want_i)) model_err = 1'b1;
        ram_lat = lat;
        ram_err = rerr;
        dmemREN = dr; dmemWEN = dw; dmemaddr = da; dmemstore = st;
        imemREN = ir; imemaddr = ia;
        got_d = 1'b0; got_i = 1'b0; got_dl = 32'h0; got_il = 32'h0;
        cyc = 0;
        while (cyc < 300 && ((want_d && !got_d) || (want_i && !got_i))) begin
            @(posedge CLK);
            @(negedge CLK);
            cyc++;
            check({nm, " hits_exclusive"}, {31'b0, ihit & dhit}, 32'h0);
            check({nm, " strobes_exclusive"}, {31'b0, ramREN & ramWEN}, 32'h0);
            if (cyc == 1 && want_d) begin
                check({nm, " ramaddr_d"}, ramaddr, da);
                check({nm, " ramWEN"}, {31'b0, ramWEN}, {31'b0, dw});
                check({nm, " ramREN_d"}, {31'b0, ramREN}, {31'b0, dr & ~dw});
                if (dw) check({nm, " ramstore"}, ramstore, st);
            end else if (cyc == 1 && want_i) begin
                check({nm, " ramaddr_i"}, ramaddr, ia);
                check({nm, " ramREN_i"}, {31'b0, ramREN}, 32'h1);
            end
            if (dhit) begin
                check({nm, " dhit_cycle"}, cyc, want_d && !got_d ? exp_d_cyc : -1);
                got_dl = dmemload;
                if ((dr && !dw) || ab) check({nm, " dmemload"}, dmemload, exp_dl);
                got_d = 1'b1;
                dmemREN = 1'b0; dmemWEN = 1'b0;
            end
            if (ihit) begin
                check({nm, " ihit_cycle"}, cyc, want_i && !got_i ? exp_i_cyc : -1);
                got_il = imemload;
                check({nm, " imemload"}, imemload, exp_il);
                got_i = 1'b1;
                imemREN = 1'b0;
            end
        end
        if (want_d) check({nm, " dhit_seen"}, {31'b0, got_d}, 32'h1);
        if (want_i) check({nm, " ihit_seen"}, {31'b0, got_i}, 32'h1);
        dmemREN = 1'b0; dmemWEN = 1'b0; imemREN = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check({nm, " err"}, {31'b0, err}, {31'b0, model_err});
    endtask

    typedef struct {
        logic        dr, dw, ir;
        logic [31:0] da, ia, st;
        int          lat;
        logic [31:0] exp_dl, exp_il;
    } vec_t;

    vec_t        vecs [0:7];
    logic [31:0] gdl, gil;
    int          cyc;
    bit          seen;

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = init_word(8'(i));
        model_err = 1'b0;
        ram_wr = '0;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h040, 32'h0, 32'h8C010004, 0, 32'h0, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h040, 32'h0, 2, 32'h0, 32'h8C010004};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 32'h0, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h100, 32'h040, 32'h0, 0, 32'hDEADBEEF, 32'h8C010004};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 32'h12345678, 0, 32'h0, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 32'h0, 3, 32'h12345678, 32'h0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h204, 32'h0, 32'hCAFEF00D, 1, 32'h0, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h204, 32'h0, 32'h0, 0, 32'hCAFEF00D, 32'h0};

        // Reset with every request asserted
        nRST = 1'b0; halt = 1'b0;
        imemREN = 1'b1; dmemREN = 1'b1; dmemWEN = 1'b1;
        imemaddr = 32'h40; dmemaddr = 32'h100; dmemstore = 32'h55;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset hits", {30'b0, ihit, dhit}, 32'h0);
        check("reset strobes", {30'b0, ramREN, ramWEN}, 32'h0);
        check("reset imemload", imemload, 32'h0);
        check("reset dmemload", dmemload, 32'h0);
        check("reset ramaddr", ramaddr, 32'h0);
        check("reset ramstore", ramstore, 32'h0);
        check("reset err", {31'b0, err}, 32'h0);
        imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
        nRST = 1'b1;
        @(negedge CLK);

        // Directed vector table
        for (int v = 0; v < 8; v++) begin
            run_txn(vecs[v].dr, vecs[v].dw, vecs[v].ir, vecs[v].da, vecs[v].ia, vecs[v].st,
                    vecs[v].lat, 1'b0, $sformatf("vec%0d", v), gdl, gil);
            if (vecs[v].dr && !vecs[v].dw) check($sformatf("vec%0d table_dl", v), gdl, vecs[v].exp_dl);
            if (vecs[v].ir) check($sformatf("vec%0d table_il", v), gil, vecs[v].exp_il);
        end

        // halt blocks fetch for 20 cycles; a data read still completes
        halt = 1'b1; imemREN = 1'b1; imemaddr = 32'h40; ram_lat = 0; ram_err = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            seen = seen | ramREN | ihit;
        end
        check("halt no_fetch", {31'b0, seen}, 32'h0);
        dmemREN = 1'b1; dmemaddr = 32'h100;
        cyc = 0;
        while (cyc < 20 && !dhit) begin
            @(posedge CLK);
            @(negedge CLK);
            cyc++;
        end
        check("halt dhit_cycle", cyc, 2);
        check("halt dmemload", dmemload, 32'hDEADBEEF);
        dmemREN = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            seen = seen | ihit | ramREN;
        end
        check("halt no_ihit_after", {31'b0, seen}, 32'h0);
        halt = 1'b0; imemREN = 1'b0;

        // halt rising during ISERV does not cancel the fetch in flight
        ram_lat = 4; imemREN = 1'b1; imemaddr = 32'h40;
        @(posedge CLK);
        @(negedge CLK);
        halt = 1'b1;
        cyc = 1;
        while (cyc < 20 && !ihit) begin
            @(posedge CLK);
            @(negedge CLK);
            cyc++;
        end
        check("halt_mid ihit_cycle", cyc, 6);
        check("halt_mid imemload", imemload, 32'h8C010004);
        imemREN = 1'b0; halt = 1'b0;
        @(posedge CLK);
        @(negedge CLK);

        // RAM stuck BUSY: abort after the timeout, error word, sticky err
        run_txn(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0, 200, 1'b0, "timeout", gdl, gil);
        check("timeout table_dl", gdl, 32'hBAD1BAD1);
        run_txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h044, 32'h0, 1, 1'b0, "after_timeout", gdl, gil);
        run_txn(1'b0, 1'b0, 1'b1, 32'h0, 32'h048, 32'h0, 0, 1'b1, "ram_error", gdl, gil);
        check("ram_error table_il", gil, 32'hBAD1BAD1);

        // Asynchronous reset in the middle of a read
        ram_lat = 5; ram_err = 1'b0; dmemREN = 1'b1; dmemaddr = 32'h200;
        @(posedge CLK);
        @(negedge CLK);
        @(posedge CLK);
        #2 nRST = 1'b0;
        #1;
        check("async_rst strobes", {30'b0, ramREN, ramWEN}, 32'h0);
        check("async_rst dhit", {31'b0, dhit}, 32'h0);
        check("async_rst err", {31'b0, err}, 32'h0);
        model_err = 1'b0;
        dmemREN = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            seen = seen | dhit | ihit;
        end
        check("async_rst no_hit", {31'b0, seen}, 32'h0);

        // Randomized transactions against the model
        for (int t = 0; t < 40; t++) begin
            int          kind, lat;
            bit          rerr;
            logic [31:0] da, ia, st;
            kind = $urandom_range(0, 4);
            lat  = $urandom_range(0, 5);
            rerr = ($urandom_range(0, 15) == 0);
            da   = 32'($urandom_range(0, 63)) << 2;
            ia   = 32'($urandom_range(0, 63)) << 2;
            st   = $urandom;
            case (kind)
                0: run_txn(1'b1, 1'b0, 1'b0, da, ia, st, lat, rerr, $sformatf("rnd%0d rd", t), gdl, gil);
                1: run_txn(1'b0, 1'b1, 1'b0, da, ia, st, lat, rerr, $sformatf("rnd%0d wr", t), gdl, gil);
                2: run_txn(1'b1, 1'b1, 1'b0, da, ia, st, lat, rerr, $sformatf("rnd%0d rdwr", t), gdl, gil);
                3: run_txn(1'b0, 1'b0, 1'b1, da, ia, st, lat, rerr, $sformatf("rnd%0d if", t), gdl, gil);
                default: run_txn(1'b1, 1'b0, 1'b1, da, ia, st, lat, rerr, $sformatf("rnd%0d dual", t), gdl, gil);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
